// File: rtl/mem_slave_ack.sv
// Memory slave for the DLX access controller's AS_N/WR_N strobe handshake.
// Inserts WAIT_STATES cycles after the strobe sample, then commits the access with a one-cycle ACK_N.
module mem_slave_ack #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              AS_N,
  input  logic              WR_N,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DIN,
  output logic              ACK_N,
  output logic [DATA_W-1:0] DOUT,
  output logic              BUSY,
  output logic [1:0]        STATE
);

  localparam int CNT_W = 4;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_WAIT    = 2'b01,
    S_HOLD    = 2'b10,
    S_ILLEGAL = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                wrn_q, wrn_d;
  logic                ack_n_q, ack_n_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                mem_we;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      wrn_q   <= 1'b1;
      ack_n_q <= 1'b1;
      dout_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wrn_q   <= wrn_d;
      ack_n_q <= ack_n_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  // The array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= din_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    wrn_d   = wrn_q;
    ack_n_d = 1'b1;
    dout_d  = dout_q;
    mem_we  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!AS_N) begin
          addr_d  = ADDR;
          din_d   = DIN;
          wrn_d   = WR_N;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (AS_N) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ack_n_d = 1'b0;
          state_d = S_HOLD;
          if (!wrn_q) begin
            mem_we = 1'b1;
          end else begin
            dout_d = mem_q[addr_q];
          end
        end
      end
      S_HOLD: begin
        // A new access is only accepted after the controller releases the strobe.
        if (AS_N) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign ACK_N = ack_n_q;
  assign DOUT  = dout_q;
  assign BUSY  = busy_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_mem_slave_ack.sv
// Randomized self-checking bench for mem_slave_ack, run on a zero-wait and a two-wait instance.
// Expected timing and data come from a simple word-array model of the handshake rules.
module tb_mem_slave_ack;

  logic        clk = 1'b0;
  logic        reset;
  logic        asN  [2];
  logic        wrN  [2];
  logic [7:0]  addr [2];
  logic [31:0] din  [2];

  logic        ackN0, ackN2, busy0, busy2;
  logic [31:0] dout0, dout2;
  logic [1:0]  state0, state2;

  bit          curSel;
  int          testsRun = 0;
  int          failures = 0;

  logic [31:0] modelMem [2][256];
  bit          known    [2][256];
  logic [31:0] lastRead [2];

  always #5 clk = ~clk;

  mem_slave_ack #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(0)) dutZero (
    .clk(clk), .reset(reset), .AS_N(asN[0]), .WR_N(wrN[0]), .ADDR(addr[0]), .DIN(din[0]),
    .ACK_N(ackN0), .DOUT(dout0), .BUSY(busy0), .STATE(state0)
  );

  mem_slave_ack #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(2)) dutTwo (
    .clk(clk), .reset(reset), .AS_N(asN[1]), .WR_N(wrN[1]), .ADDR(addr[1]), .DIN(din[1]),
    .ACK_N(ackN2), .DOUT(dout2), .BUSY(busy2), .STATE(state2)
  );

  wire        obsAck   = curSel ? ackN2  : ackN0;
  wire [31:0] obsDout  = curSel ? dout2  : dout0;
  wire        obsBusy  = curSel ? busy2  : busy0;
  wire [1:0]  obsState = curSel ? state2 : state0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // One full handshake: strobe, wait for ACK, hold extraHold more cycles, release.
  task automatic applyStimulus(input bit sel, input bit isWrite, input logic [7:0] a,
                               input logic [31:0] d, input int extraHold);
    int ws, ackEdge, lowCount;
    curSel  = sel;
    ws      = sel ? 2 : 0;
    ackEdge = -1;
    lowCount = 0;
    @(negedge clk);
    asN[sel] = 1'b0; wrN[sel] = !isWrite; addr[sel] = a; din[sel] = d;
    @(posedge clk);
    for (int i = 1; i <= ws + 2 + extraHold; i++) begin
      @(negedge clk);
      addr[sel] = 8'($urandom); din[sel] = $urandom; wrN[sel] = 1'($urandom);
      @(posedge clk); #1;
      if (obsAck == 1'b0) begin
        lowCount++;
        if (ackEdge < 0) ackEdge = i;
      end
      if (i == ws + 1 && !isWrite && known[sel][a]) checkOutput("readData", obsDout, modelMem[sel][a]);
    end
    checkOutput("ackEdge", ackEdge, ws + 1);
    checkOutput("ackPulses", lowCount, 1);
    checkOutput("holdState", {30'd0, obsState}, 32'd2);
    checkOutput("holdBusy", {31'd0, obsBusy}, 32'd1);
    if (isWrite) begin
      modelMem[sel][a] = d;
      known[sel][a] = 1'b1;
    end else if (known[sel][a]) begin
      lastRead[sel] = modelMem[sel][a];
    end
    if (isWrite || known[sel][a]) checkOutput("doutHeld", obsDout, lastRead[sel]);
    @(negedge clk);
    asN[sel] = 1'b1;
    @(posedge clk); #1;
    checkOutput("releaseState", {30'd0, obsState}, 32'd0);
    checkOutput("releaseBusy", {31'd0, obsBusy}, 32'd0);
    checkOutput("releaseAck", {31'd0, obsAck}, 32'd1);
  endtask

  // Strobe dropped one edge after sampling: the write must vanish without an ACK.
  task automatic abortWrite(input logic [7:0] a, input logic [31:0] d);
    int lowCount = 0;
    curSel = 1'b1;
    @(negedge clk);
    asN[1] = 1'b0; wrN[1] = 1'b0; addr[1] = a; din[1] = d;
    @(posedge clk);
    @(negedge clk);
    asN[1] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (obsAck == 1'b0) lowCount++;
      if (i == 2) checkOutput("abortState", {30'd0, obsState}, 32'd0);
    end
    checkOutput("abortNoAck", lowCount, 0);
    checkOutput("abortDout", obsDout, lastRead[1]);
  endtask

  task automatic resetMidWait(input logic [7:0] a, input logic [31:0] d);
    curSel = 1'b1;
    @(negedge clk);
    asN[1] = 1'b0; wrN[1] = 1'b0; addr[1] = a; din[1] = d;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkOutput("rstAck", {31'd0, obsAck}, 32'd1);
    checkOutput("rstState", {30'd0, obsState}, 32'd0);
    checkOutput("rstBusy", {31'd0, obsBusy}, 32'd0);
    checkOutput("rstDout", obsDout, 32'd0);
    asN[1] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lastRead[0] = '0;
    lastRead[1] = '0;
  endtask

  initial begin
    logic [7:0] pairAddr [4];
    logic [7:0] pick;
    bit         wr;
    pairAddr = '{8'h00, 8'hFF, 8'h7F, 8'h80};
    for (int s = 0; s < 2; s++) begin
      asN[s] = 1'b1; wrN[s] = 1'b1; addr[s] = '0; din[s] = '0; lastRead[s] = '0;
      for (int j = 0; j < 256; j++) known[s][j] = 1'b0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetAck0", {31'd0, ackN0}, 32'd1);
    checkOutput("resetAck2", {31'd0, ackN2}, 32'd1);
    checkOutput("resetDout2", dout2, 32'd0);
    checkOutput("resetBusy2", {31'd0, busy2}, 32'd0);
    checkOutput("resetState2", {30'd0, state2}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 0);
    applyStimulus(1'b1, 1'b0, 8'h10, 32'h0, 0);

    applyStimulus(1'b0, 1'b1, 8'h10, $urandom, 0);
    applyStimulus(1'b0, 1'b0, 8'h10, 32'h0, 0);

    applyStimulus(1'b1, 1'b1, 8'h20, 32'hA5A5C3C3, 0);
    abortWrite(8'h20, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 8'h20, 32'h0, 0);

    applyStimulus(1'b1, 1'b0, 8'h10, 32'h0, 6);
    applyStimulus(1'b1, 1'b1, 8'h33, $urandom, 0);

    resetMidWait(8'h10, 32'h55555555);
    applyStimulus(1'b1, 1'b0, 8'h10, 32'h0, 0);

    for (int s = 0; s < 2; s++) begin
      for (int p = 0; p < 4; p++) begin
        applyStimulus(1'(s), 1'b1, pairAddr[p], $urandom, 0);
        applyStimulus(1'(s), 1'b0, pairAddr[p], 32'h0, 0);
      end
    end

    for (int n = 0; n < 40; n++) begin
      curSel = 1'($urandom);
      pick   = pairAddr[$urandom_range(0, 3)] ^ 8'($urandom_range(0, 3));
      wr     = !known[curSel][pick] || ($urandom_range(0, 1) == 1);
      applyStimulus(curSel, wr, pick, $urandom, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
